// File: rtl/uart_rx_host_ctrl.sv
// UART receiver read-handshake sequencer with a small capture FIFO,
// sticky error flags, an interrupt line and a two-register CPU read port.
module uart_rx_host_ctrl #(
    parameter int DEPTH     = 4,
    parameter int AW        = 2,
    parameter int DW        = 32,
    parameter int TO_CYCLES = 255
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          RxRDY,
    input  logic          RxParityErr,
    input  logic [DW-1:0] RxData,
    output logic          RD,
    input  logic          CpuRd,
    input  logic          CpuAddr,
    input  logic          ClrErr,
    input  logic          IrqEn,
    output logic [DW-1:0] CpuDout,
    output logic          IRQ
);

    localparam int TW = $clog2(TO_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        CAPTURE,
        HOLD
    } state_t;

    state_t        state_q;
    logic          rd_q;
    logic [TW-1:0] to_cnt_q;

    logic [DW:0]   mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovr_q, ovr_d;
    logic          to_q, to_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          irq_q, irq_d;

    logic [DW-1:0] status;
    logic [DW:0]   head;
    logic          empty, full;
    logic          push, pop, push_ok;
    logic          ovr_set, to_hit;

    assign head    = mem_q[rptr_q];
    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign push    = (state_q == CAPTURE);
    assign pop     = CpuRd & ~CpuAddr & ~empty;
    // a pop in the same cycle frees the slot the push needs
    assign push_ok = push & (~full | pop);
    assign ovr_set = push & full & ~pop;
    assign to_hit  = (state_q == HOLD) & RxRDY
                   & (to_cnt_q == TW'(TO_CYCLES - 1));

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        status          = '0;
        status[0]       = ~empty;
        status[1]       = full;
        status[2]       = ovr_q;
        status[3]       = ~empty & head[DW];
        status[4]       = to_q;
        status[5+AW:5]  = count_q;

        dout_d = dout_q;
        if (CpuRd) begin
            if (CpuAddr) begin
                dout_d = status;
            end else if (empty) begin
                dout_d = '0;
            end else begin
                dout_d = head[DW-1:0];
            end
        end

        ovr_d = ovr_set | (ovr_q & ~ClrErr);
        to_d  = to_hit | (to_q & ~ClrErr);
        irq_d = IrqEn & ((count_d != '0) | ovr_d | to_d);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= IDLE;
            rd_q     <= 1'b0;
            to_cnt_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (RxRDY) begin
                        state_q <= ASSERT;
                        rd_q    <= 1'b1;
                    end
                end
                ASSERT: begin
                    state_q <= CAPTURE;
                end
                CAPTURE: begin
                    state_q  <= HOLD;
                    to_cnt_q <= '0;
                end
                HOLD: begin
                    if (!RxRDY || to_hit) begin
                        state_q <= IDLE;
                        rd_q    <= 1'b0;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    rd_q    <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovr_q   <= 1'b0;
            to_q    <= 1'b0;
            dout_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovr_q   <= ovr_d;
            to_q    <= to_d;
            dout_q  <= dout_d;
            irq_q   <= irq_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset && push_ok) begin
            mem_q[wptr_q] <= {RxParityErr, RxData};
        end
    end

    assign RD      = rd_q;
    assign CpuDout = dout_q;
    assign IRQ     = irq_q;

endmodule

// File: tb/tb_uart_rx_host_ctrl.sv
// Directed bench for uart_rx_host_ctrl: queue-based reference model
// compared every cycle, plus literal expectations for each scenario.
module tb_uart_rx_host_ctrl;

    localparam int DEPTH = 4;
    localparam int TO    = 255;

    logic        Clock;
    logic        Reset;
    logic        RxRDY;
    logic        RxParityErr;
    logic [31:0] RxData;
    logic        RD;
    logic        CpuRd;
    logic        CpuAddr;
    logic        ClrErr;
    logic        IrqEn;
    logic [31:0] CpuDout;
    logic        IRQ;

    uart_rx_host_ctrl dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .RxRDY       (RxRDY),
        .RxParityErr (RxParityErr),
        .RxData      (RxData),
        .RD          (RD),
        .CpuRd       (CpuRd),
        .CpuAddr     (CpuAddr),
        .ClrErr      (ClrErr),
        .IrqEn       (IrqEn),
        .CpuDout     (CpuDout),
        .IRQ         (IRQ)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: the FIFO is a queue, the handshake is tracked
    // as the number of cycles RD has been high.
    logic [32:0] q[$];
    bit          m_valid = 0;
    bit          busy;
    int          k;
    bit          m_rd, m_ovr, m_to, m_irq;
    logic [31:0] m_dout;
    logic [31:0] st;
    bit          pop, push, ovr_set, to_set;

    always @(posedge Clock) begin
        if (Reset) begin
            q.delete();
            busy = 0; k = 0;
            m_rd = 0; m_ovr = 0; m_to = 0; m_irq = 0;
            m_dout = '0;
            m_valid = 1;
        end else begin
            st = '0;
            st[0] = q.size() != 0;
            st[1] = q.size() == DEPTH;
            st[2] = m_ovr;
            st[3] = (q.size() != 0) ? q[0][32] : 1'b0;
            st[4] = m_to;
            st[7:5] = 3'(q.size());
            pop = CpuRd && !CpuAddr && q.size() > 0;
            if (CpuRd)
                m_dout = CpuAddr ? st
                       : ((q.size() != 0) ? q[0][31:0] : 32'h0);
            push = 0; to_set = 0; ovr_set = 0;
            if (busy) begin
                k++;
                if (k == 2) push = 1;
                else if (k >= 3) begin
                    if (!RxRDY) busy = 0;
                    else if (k - 2 == TO) begin
                        to_set = 1;
                        busy = 0;
                    end
                end
            end else if (RxRDY) begin
                busy = 1;
                k = 0;
            end
            m_rd = busy;
            if (pop) void'(q.pop_front());
            if (push) begin
                if (q.size() < DEPTH) q.push_back({RxParityErr, RxData});
                else ovr_set = 1;
            end
            m_ovr = ovr_set ? 1'b1 : (ClrErr ? 1'b0 : m_ovr);
            m_to  = to_set ? 1'b1 : (ClrErr ? 1'b0 : m_to);
            m_irq = IrqEn && (q.size() > 0 || m_ovr || m_to);
        end
    end

    always @(negedge Clock) begin
        if (m_valid) begin
            check("cyc_RD", {31'b0, RD}, {31'b0, m_rd});
            check("cyc_IRQ", {31'b0, IRQ}, {31'b0, m_irq});
            check("cyc_CpuDout", CpuDout, m_dout);
        end
    end

    task automatic do_reset();
        Reset = 1;
        @(negedge Clock);
        Reset = 0;
    endtask

    task automatic cpu_read(input logic a, output logic [31:0] v);
        CpuRd = 1; CpuAddr = a;
        @(negedge Clock);
        CpuRd = 0;
        v = CpuDout;
    endtask

    task automatic send(input logic [31:0] d, input logic pe, input int h,
                        input bit pop_cap, output int rdn,
                        output logic [31:0] popped);
        RxData = d; RxParityErr = pe; RxRDY = 1;
        rdn = 0; popped = '0;
        for (int i = 1; i <= 2 + h; i++) begin
            @(negedge Clock);
            if (RD) rdn++;
            if (pop_cap && i == 2) begin
                CpuRd = 1; CpuAddr = 0;
            end
            if (pop_cap && i == 3) begin
                CpuRd = 0;
                popped = CpuDout;
            end
        end
        RxRDY = 0;
        @(negedge Clock);
        if (RD) rdn++;
    endtask

    logic [31:0] v, p;
    int          n;
    bit          got;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1; RxRDY = 0; RxParityErr = 0; RxData = '0;
        CpuRd = 0; CpuAddr = 0; ClrErr = 0; IrqEn = 1;
        repeat (2) @(negedge Clock);
        check("rst_RD", {31'b0, RD}, 32'h0);
        check("rst_dout", CpuDout, 32'h0);
        check("rst_IRQ", {31'b0, IRQ}, 32'h0);
        Reset = 0;
        @(negedge Clock);

        send(32'hDEADBEEF, 0, 2, 0, n, p);
        check("single_rd_len", n, 4);
        cpu_read(1, v); check("single_stat", v, 32'h21);
        cpu_read(0, v); check("single_data", v, 32'hDEADBEEF);
        cpu_read(1, v); check("single_stat2", v, 32'h00);

        send(32'h55, 1, 1, 0, n, p);
        check("par_rd_len", n, 3);
        cpu_read(1, v); check("par_stat", v, 32'h29);
        cpu_read(0, v); check("par_data", v, 32'h55);
        cpu_read(1, v); check("par_stat2", v, 32'h00);

        for (int i = 0; i < 5; i++)
            send(32'hA000_0000 + i, 0, 1, 0, n, p);
        cpu_read(1, v); check("ovr_stat", v, 32'h87);
        for (int i = 0; i < 4; i++) begin
            cpu_read(0, v); check("ovr_data", v, 32'hA000_0000 + i);
        end
        cpu_read(1, v); check("ovr_stat_empty", v, 32'h04);
        check("ovr_irq", {31'b0, IRQ}, 32'h1);
        ClrErr = 1; @(negedge Clock); ClrErr = 0;
        check("clr_irq", {31'b0, IRQ}, 32'h0);
        cpu_read(1, v); check("clr_stat", v, 32'h00);

        do_reset();
        for (int i = 0; i < 4; i++)
            send(32'hB000_0000 + i, 0, 1, 0, n, p);
        send(32'hB000_0004, 0, 1, 1, n, p);
        check("fp_popped", p, 32'hB000_0000);
        cpu_read(1, v); check("fp_stat", v, 32'h83);
        for (int i = 1; i < 5; i++) begin
            cpu_read(0, v); check("fp_data", v, 32'hB000_0000 + i);
        end

        do_reset();
        RxData = 32'hC0C0_C0C0; RxParityErr = 0; RxRDY = 1;
        n = 0; got = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge Clock);
            if (RD) n++;
            else if (n > 0) begin
                got = 1;
                break;
            end
        end
        check("to_end", {31'b0, got}, 32'h1);
        check("to_rd_len", n, TO + 2);
        check("to_irq", {31'b0, IRQ}, 32'h1);
        cpu_read(1, v); check("to_stat", v, 32'h31);
        check("to_restart", {31'b0, RD}, 32'h1);
        repeat (2) @(negedge Clock);
        RxRDY = 0;
        @(negedge Clock);
        cpu_read(1, v); check("to_stat2", v, 32'h51);
        ClrErr = 1; @(negedge Clock); ClrErr = 0;
        cpu_read(1, v); check("to_clr", v, 32'h41);

        do_reset();
        RxData = 32'hD0D0_0001; RxRDY = 1;
        repeat (3) @(negedge Clock);
        Reset = 1;
        @(negedge Clock);
        check("rh_RD", {31'b0, RD}, 32'h0);
        Reset = 0; RxRDY = 0;
        cpu_read(1, v); check("rh_stat", v, 32'h00);
        send(32'hE0E0_0002, 0, 1, 0, n, p);
        cpu_read(1, v); check("ep_stat", v, 32'h21);
        cpu_read(0, v); check("ep_data", v, 32'hE0E0_0002);
        cpu_read(0, v); check("ep_empty", v, 32'h0);
        cpu_read(1, v); check("ep_stat2", v, 32'h00);

        repeat (2) @(negedge Clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
